mm_bram_feeder: RTL and testbench



---
 rtl/mm_bram_feeder.sv | 182 ++++++++++++++++++
 tb/tb_mm_bram_feeder.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_bram_feeder.sv
// Read sequencer and skew stage between the banked A/B BRAMs and the systolic array.
// Walks both banks once per start pulse and re-times bank words into a diagonal wavefront.
module mm_bram_feeder #(
  parameter int M      = 8,
  parameter int N1     = 4,
  parameter int N2     = 4,
  parameter int D_W    = 8,
  parameter int RD_LAT = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  output logic [$clog2(M*M/N1)-1:0]       rd_addr_A,
  output logic [$clog2(M*M/N2)-1:0]       rd_addr_B,
  input  logic [N1-1:0][D_W-1:0]          A_bram,
  input  logic [N2-1:0][D_W-1:0]          B_bram,
  output logic [N1-1:0][D_W-1:0]          A_out,
  output logic [N2-1:0][D_W-1:0]          B_out,
  output logic [N1-1:0]                   A_valid,
  output logic [N2-1:0]                   B_valid,
  output logic                            busy,
  output logic                            done
);

  localparam int LA        = M * M / N1;
  localparam int LB        = M * M / N2;
  localparam int LMAX      = (LA > LB) ? LA : LB;
  localparam int NMAX      = (N1 > N2) ? N1 : N2;
  localparam int CW        = $clog2(LMAX) + 1;
  localparam int AWA       = $clog2(LA);
  localparam int AWB       = $clog2(LB);
  localparam int DRAIN_LEN = RD_LAT + NMAX - 1;
  localparam int DCW       = $clog2(DRAIN_LEN) + 1;

  localparam logic [CW-1:0]  LA_C       = CW'(LA);
  localparam logic [CW-1:0]  LB_C       = CW'(LB);
  localparam logic [CW-1:0]  LMAX_LAST  = CW'(LMAX - 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cntNext;
  logic [DCW-1:0]   r_drainCnt;
  logic [DCW-1:0]   w_drainCntNext;
  logic [AWA-1:0]   r_rdAddrA;
  logic [AWB-1:0]   r_rdAddrB;
  logic             w_issA;
  logic             w_issB;
  logic [RD_LAT-1:0] r_vPipeA;
  logic [RD_LAT-1:0] r_vPipeB;
  logic             w_alignA;
  logic             w_alignB;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_drainCnt <= '0;
      r_rdAddrA  <= '0;
      r_rdAddrB  <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_cnt      <= w_cntNext;
      r_drainCnt <= w_drainCntNext;
      // Addresses are registered from the next count and saturate at the last bank word
      r_rdAddrA  <= (w_cntNext < LA_C) ? w_cntNext[AWA-1:0] : AWA'(LA - 1);
      r_rdAddrB  <= (w_cntNext < LB_C) ? w_cntNext[AWB-1:0] : AWB'(LB - 1);
    end
  end

  always_comb begin
    w_stateNext    = r_state;
    w_cntNext      = r_cnt;
    w_drainCntNext = r_drainCnt;
    case (r_state)
      S_IDLE: begin
        w_cntNext      = '0;
        w_drainCntNext = '0;
        if (start) w_stateNext = S_ISSUE;
      end
      S_ISSUE: begin
        if (r_cnt == LMAX_LAST) w_stateNext = S_DRAIN;
        else                    w_cntNext   = r_cnt + CW'(1);
      end
      S_DRAIN: begin
        if (r_drainCnt == DRAIN_LAST) w_stateNext    = S_DONE;
        else                          w_drainCntNext = r_drainCnt + DCW'(1);
      end
      S_DONE: begin
        w_stateNext    = S_IDLE;
        w_cntNext      = '0;
        w_drainCntNext = '0;
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  assign w_issA    = (r_state == S_ISSUE) && (r_cnt < LA_C);
  assign w_issB    = (r_state == S_ISSUE) && (r_cnt < LB_C);
  assign rd_addr_A = r_rdAddrA;
  assign rd_addr_B = r_rdAddrB;
  assign busy      = (r_state == S_ISSUE) || (r_state == S_DRAIN);
  assign done      = (r_state == S_DONE);

  // Issue valids are delayed to line up with the bank read latency
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vPipeA <= '0;
      r_vPipeB <= '0;
    end else begin
      r_vPipeA[0] <= w_issA;
      r_vPipeB[0] <= w_issB;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vPipeA[i] <= r_vPipeA[i-1];
        r_vPipeB[i] <= r_vPipeB[i-1];
      end
    end
  end

  assign w_alignA = r_vPipeA[RD_LAT-1];
  assign w_alignB = r_vPipeB[RD_LAT-1];

  // Lane x sits behind x skew registers; data is zeroed whenever its valid is low
  for (genvar x = 0; x < N1; x++) begin : g_skewA
    if (x == 0) begin : g_pass
      assign A_valid[0] = w_alignA;
      assign A_out[0]   = w_alignA ? A_bram[0] : '0;
    end else begin : g_line
      logic [x-1:0]          r_skV;
      logic [x-1:0][D_W-1:0] r_skD;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_skV <= '0;
          r_skD <= '0;
        end else begin
          r_skV[0] <= w_alignA;
          r_skD[0] <= w_alignA ? A_bram[x] : '0;
          for (int i = 1; i < x; i++) begin
            r_skV[i] <= r_skV[i-1];
            r_skD[i] <= r_skD[i-1];
          end
        end
      end
      assign A_valid[x] = r_skV[x-1];
      assign A_out[x]   = r_skD[x-1];
    end
  end

  for (genvar y = 0; y < N2; y++) begin : g_skewB
    if (y == 0) begin : g_pass
      assign B_valid[0] = w_alignB;
      assign B_out[0]   = w_alignB ? B_bram[0] : '0;
    end else begin : g_line
      logic [y-1:0]          r_skV;
      logic [y-1:0][D_W-1:0] r_skD;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_skV <= '0;
          r_skD <= '0;
        end else begin
          r_skV[0] <= w_alignB;
          r_skD[0] <= w_alignB ? B_bram[y] : '0;
          for (int i = 1; i < y; i++) begin
            r_skV[i] <= r_skV[i-1];
            r_skD[i] <= r_skD[i-1];
          end
        end
      end
      assign B_valid[y] = r_skV[y-1];
      assign B_out[y]   = r_skD[y-1];
    end
  end

endmodule

// File: tb/tb_mm_bram_feeder.sv
// Bench for mm_bram_feeder: a square-bank instance (u0) and an unequal-bank instance (u1)
// checked every cycle against a wavefront timing model plus directed literal checks.
module tb_mm_bram_feeder;

  localparam int M   = 8;
  localparam int RDL = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // u0: N1 = N2 = 4 (LA = LB = 16); u1: N1 = 2, N2 = 4 (LA = 32, LB = 16)
  logic             rst0, start0, busy0, done0;
  logic [3:0]       rdA0, rdB0;
  logic [3:0][7:0]  aBram0, bBram0, aOut0, bOut0;
  logic [3:0]       aValid0, bValid0;

  logic             rst1, start1, busy1, done1;
  logic [4:0]       rdA1;
  logic [3:0]       rdB1;
  logic [1:0][7:0]  aBram1, aOut1;
  logic [3:0][7:0]  bBram1, bOut1;
  logic [1:0]       aValid1;
  logic [3:0]       bValid1;

  mm_bram_feeder #(.M(M), .N1(4), .N2(4), .D_W(8), .RD_LAT(RDL)) u0 (
    .clk(clk), .rst(rst0), .start(start0),
    .rd_addr_A(rdA0), .rd_addr_B(rdB0),
    .A_bram(aBram0), .B_bram(bBram0),
    .A_out(aOut0), .B_out(bOut0),
    .A_valid(aValid0), .B_valid(bValid0),
    .busy(busy0), .done(done0)
  );

  mm_bram_feeder #(.M(M), .N1(2), .N2(4), .D_W(8), .RD_LAT(RDL)) u1 (
    .clk(clk), .rst(rst1), .start(start1),
    .rd_addr_A(rdA1), .rd_addr_B(rdB1),
    .A_bram(aBram1), .B_bram(bBram1),
    .A_out(aOut1), .B_out(bOut1),
    .A_valid(aValid1), .B_valid(bValid1),
    .busy(busy1), .done(done1)
  );

  // Bank model: RDL-cycle read latency, word = bank*32 + addr
  logic [RDL-1:0][3:0] pA0, pB0, pB1;
  logic [RDL-1:0][4:0] pA1;

  always @(posedge clk) begin
    pA0[0] <= rdA0;
    pB0[0] <= rdB0;
    pA1[0] <= rdA1;
    pB1[0] <= rdB1;
    for (int i = 1; i < RDL; i++) begin
      pA0[i] <= pA0[i-1];
      pB0[i] <= pB0[i-1];
      pA1[i] <= pA1[i-1];
      pB1[i] <= pB1[i-1];
    end
  end

  always_comb begin
    for (int x = 0; x < 4; x++) begin
      aBram0[x] = 8'(x * 32 + int'(pA0[RDL-1]));
      bBram0[x] = 8'(x * 32 + int'(pB0[RDL-1]));
      bBram1[x] = 8'(x * 32 + int'(pB1[RDL-1]));
    end
    for (int x = 0; x < 2; x++) aBram1[x] = 8'(x * 32 + int'(pA1[RDL-1]));
  end

  int  cyc = 0;
  int  runT0 [2] = '{-1, -1};
  bit  chkEn = 1'b0;
  int  passCnt = 0;
  int  totalCnt = 0;
  int  doneCnt0 = 0;
  int  vcA0 [4], vcB0 [4], vcA1 [2], vcB1 [4];

  function automatic int doneCycle(input int t0, input int la, input int lb,
                                   input int n1, input int n2);
    return t0 + ((la > lb) ? la : lb) + RDL + ((n1 > n2) ? n1 : n2);
  endfunction

  // Address index of the word on a lane in cycle c, or -1 when the lane is idle
  function automatic int laneIdx(input int c, input int t0, input int x, input int len);
    int k;
    if (t0 < 0) return -1;
    k = c - (t0 + 1 + RDL + x);
    return (k >= 0 && k < len) ? k : -1;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    totalCnt++;
    if (act == exp) passCnt++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic compareModel(input string tag, input int t0, input int n1, input int n2,
                              input int la, input int lb,
                              input logic [3:0][7:0] aOut, input logic [3:0][7:0] bOut,
                              input logic [3:0] aV, input logic [3:0] bV,
                              input int rdA, input int rdB, input logic busyV, input logic doneV);
    int k, dc, lmax;
    lmax = (la > lb) ? la : lb;
    dc   = doneCycle(t0, la, lb, n1, n2);
    for (int x = 0; x < n1; x++) begin
      k = laneIdx(cyc, t0, x, la);
      checkOutput($sformatf("%s.A_valid[%0d]", tag, x), int'(aV[x]), (k >= 0) ? 1 : 0);
      checkOutput($sformatf("%s.A_out[%0d]", tag, x), int'(aOut[x]), (k >= 0) ? x * 32 + k : 0);
    end
    for (int y = 0; y < n2; y++) begin
      k = laneIdx(cyc, t0, y, lb);
      checkOutput($sformatf("%s.B_valid[%0d]", tag, y), int'(bV[y]), (k >= 0) ? 1 : 0);
      checkOutput($sformatf("%s.B_out[%0d]", tag, y), int'(bOut[y]), (k >= 0) ? y * 32 + k : 0);
    end
    checkOutput({tag, ".busy"}, int'(busyV), (t0 >= 0 && cyc > t0 && cyc < dc) ? 1 : 0);
    checkOutput({tag, ".done"}, int'(doneV), (t0 >= 0 && cyc == dc) ? 1 : 0);
    if (t0 < 0 || cyc > dc) begin
      checkOutput({tag, ".rd_addr_A"}, rdA, 0);
      checkOutput({tag, ".rd_addr_B"}, rdB, 0);
    end else if (cyc <= t0 + lmax) begin
      checkOutput({tag, ".rd_addr_A"}, rdA, (cyc - t0 - 1 < la) ? cyc - t0 - 1 : la - 1);
      checkOutput({tag, ".rd_addr_B"}, rdB, (cyc - t0 - 1 < lb) ? cyc - t0 - 1 : lb - 1);
    end
  endtask

  // Run tracking: a start is taken only when no run is in flight and reset is low
  always @(posedge clk) begin
    if (rst0) runT0[0] = -1;
    else if (start0 && (runT0[0] < 0 || cyc > doneCycle(runT0[0], 16, 16, 4, 4))) runT0[0] = cyc;
    if (rst1) runT0[1] = -1;
    else if (start1 && (runT0[1] < 0 || cyc > doneCycle(runT0[1], 32, 16, 2, 4))) runT0[1] = cyc;
    cyc++;
  end

  always @(negedge clk) begin
    if (chkEn) begin
      compareModel("u0", runT0[0], 4, 4, 16, 16, aOut0, bOut0, aValid0, bValid0,
                   int'(rdA0), int'(rdB0), busy0, done0);
      compareModel("u1", runT0[1], 2, 4, 32, 16, {16'h0, aOut1}, bOut1, {2'b00, aValid1}, bValid1,
                   int'(rdA1), int'(rdB1), busy1, done1);
      if (done0) doneCnt0++;
      for (int x = 0; x < 4; x++) begin
        vcA0[x] += int'(aValid0[x]);
        vcB0[x] += int'(bValid0[x]);
        vcB1[x] += int'(bValid1[x]);
      end
      for (int x = 0; x < 2; x++) vcA1[x] += int'(aValid1[x]);
    end
  end

  task automatic applyStimulus(input int inst, input logic s, input logic r);
    if (inst == 0) begin
      start0 = s;
      rst0   = r;
    end else begin
      start1 = s;
      rst1   = r;
    end
  endtask

  task automatic gotoCycle(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clearCounts();
    doneCnt0 = 0;
    for (int x = 0; x < 4; x++) begin
      vcA0[x] = 0;
      vcB0[x] = 0;
      vcB1[x] = 0;
    end
    for (int x = 0; x < 2; x++) vcA1[x] = 0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t0, t0b;
    clearCounts();
    applyStimulus(0, 1'b0, 1'b1);
    applyStimulus(1, 1'b0, 1'b1);
    gotoCycle(1);
    chkEn = 1'b1;
    gotoCycle(3);
    applyStimulus(0, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, 1'b0);

    // Basic run, restart attempts while busy and on done, then a back-to-back run
    gotoCycle(cyc + 2);
    clearCounts();
    t0 = cyc;
    applyStimulus(0, 1'b1, 1'b0);
    gotoCycle(t0 + 1);
    applyStimulus(0, 1'b0, 1'b0);
    gotoCycle(t0 + 2);
    @(negedge clk) checkOutput("lit.u0.A_valid0_early", int'(aValid0[0]), 0);
    gotoCycle(t0 + 3);
    @(negedge clk);
    checkOutput("lit.u0.A_valid0_rise", int'(aValid0[0]), 1);
    checkOutput("lit.u0.rd_addr_A_k2", int'(rdA0), 2);
    gotoCycle(t0 + 4);
    @(negedge clk) checkOutput("lit.u0.A_out0_k1", int'(aOut0[0]), 1);
    gotoCycle(t0 + 5);
    applyStimulus(0, 1'b1, 1'b0);
    gotoCycle(t0 + 6);
    applyStimulus(0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("lit.u0.A_out3_k0", int'(aOut0[3]), 96);
    checkOutput("lit.u0.A_valid3_rise", int'(aValid0[3]), 1);
    gotoCycle(t0 + 16);
    @(negedge clk) checkOutput("lit.u0.rd_addr_A_last", int'(rdA0), 15);
    gotoCycle(t0 + 21);
    @(negedge clk) checkOutput("lit.u0.A_out3_k15", int'(aOut0[3]), 111);
    gotoCycle(t0 + 22);
    applyStimulus(0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("lit.u0.done_run1", int'(done0), 1);
    checkOutput("lit.u0.busy_at_done", int'(busy0), 0);
    checkOutput("lit.u0.A_valid0_count", vcA0[0], 16);
    checkOutput("lit.u0.A_valid3_count", vcA0[3], 16);
    checkOutput("lit.u0.B_valid2_count", vcB0[2], 16);
    gotoCycle(t0 + 23);
    t0b = t0 + 23;
    gotoCycle(t0 + 24);
    applyStimulus(0, 1'b0, 1'b0);
    gotoCycle(t0b + 6);
    @(negedge clk) checkOutput("lit.u0.run2_A_out3_k0", int'(aOut0[3]), 96);
    gotoCycle(t0b + 22);
    @(negedge clk) checkOutput("lit.u0.run2_done", int'(done0), 1);
    gotoCycle(t0b + 23);
    @(negedge clk) checkOutput("lit.u0.done_pulses", doneCnt0, 2);

    // Reset held three cycles mid-issue, then a fresh run one cycle after release
    gotoCycle(cyc + 2);
    t0 = cyc;
    applyStimulus(0, 1'b1, 1'b0);
    gotoCycle(t0 + 1);
    applyStimulus(0, 1'b0, 1'b0);
    gotoCycle(t0 + 8);
    applyStimulus(0, 1'b0, 1'b1);
    gotoCycle(t0 + 9);
    @(negedge clk);
    checkOutput("lit.u0.rst_busy", int'(busy0), 0);
    checkOutput("lit.u0.rst_A_valid", int'(aValid0), 0);
    checkOutput("lit.u0.rst_rd_addr_A", int'(rdA0), 0);
    gotoCycle(t0 + 11);
    applyStimulus(0, 1'b0, 1'b0);
    gotoCycle(t0 + 12);
    applyStimulus(0, 1'b1, 1'b0);
    t0b = t0 + 12;
    gotoCycle(t0 + 13);
    applyStimulus(0, 1'b0, 1'b0);
    gotoCycle(t0b + 6);
    @(negedge clk) checkOutput("lit.u0.post_rst_A_out3_k0", int'(aOut0[3]), 96);
    gotoCycle(t0b + 22);
    @(negedge clk) checkOutput("lit.u0.post_rst_done", int'(done0), 1);

    // Unequal banks on u1
    gotoCycle(cyc + 2);
    clearCounts();
    t0 = cyc;
    applyStimulus(1, 1'b1, 1'b0);
    gotoCycle(t0 + 1);
    applyStimulus(1, 1'b0, 1'b0);
    gotoCycle(t0 + 20);
    @(negedge clk) checkOutput("lit.u1.rd_addr_B_hold", int'(rdB1), 15);
    gotoCycle(t0 + 30);
    @(negedge clk);
    checkOutput("lit.u1.rd_addr_B_hold2", int'(rdB1), 15);
    checkOutput("lit.u1.rd_addr_A_k29", int'(rdA1), 29);
    gotoCycle(t0 + 37);
    @(negedge clk) checkOutput("lit.u1.done_early", int'(done1), 0);
    gotoCycle(t0 + 38);
    @(negedge clk) checkOutput("lit.u1.done", int'(done1), 1);
    gotoCycle(t0 + 40);
    @(negedge clk);
    for (int x = 0; x < 2; x++) checkOutput($sformatf("lit.u1.A_valid%0d_count", x), vcA1[x], 32);
    for (int y = 0; y < 4; y++) checkOutput($sformatf("lit.u1.B_valid%0d_count", y), vcB1[y], 16);

    // Reset during drain on u0: wavefront dies at once and no done follows
    gotoCycle(cyc + 2);
    clearCounts();
    t0 = cyc;
    applyStimulus(0, 1'b1, 1'b0);
    gotoCycle(t0 + 1);
    applyStimulus(0, 1'b0, 1'b0);
    gotoCycle(t0 + 18);
    applyStimulus(0, 1'b0, 1'b1);
    @(negedge clk) checkOutput("lit.u0.drain_A_valid2", int'(aValid0[2]), 1);
    gotoCycle(t0 + 19);
    applyStimulus(0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("lit.u0.drain_rst_A_valid", int'(aValid0), 0);
    checkOutput("lit.u0.drain_rst_B_valid", int'(bValid0), 0);
    gotoCycle(t0 + 30);
    @(negedge clk) checkOutput("lit.u0.drain_rst_no_done", doneCnt0, 0);

    gotoCycle(cyc + 3);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
